// File: rtl/prim_dstack.sv
// prim_dstack: data stack with T and N held in flops and deeper entries
// spilled to a synchronous-read array. Ops that need the third entry take
// two cycles: the array read is issued on acceptance and consumed in READ.
// Optional build macro PRIM_DSTACK_GUARD_EN enables depth checking with
// overflow/underflow pulses; without it ops always execute, depth clamps
// at 0 and CAP, and the spill pointer wraps (circular stack).
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | ready; single-cycle ops complete here, two-cycle ops issue a read
// READ  | not ready; array read data arrives and T/N/array are updated
module prim_dstack #(
    parameter int WIDTH = 16,
    parameter int DSS   = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_t,
    output logic [WIDTH-1:0] o_n,
    output logic [DSS+1:0]   o_depth,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int DW    = DSS + 2;
    localparam int MEM_N = 2 ** DSS;
    localparam logic [DW-1:0] CAP = DW'(MEM_N + 2);

    localparam logic [3:0] OP_PUSH  = 4'd1;
    localparam logic [3:0] OP_DROP  = 4'd2;
    localparam logic [3:0] OP_DUP   = 4'd3;
    localparam logic [3:0] OP_SWAP  = 4'd4;
    localparam logic [3:0] OP_OVER  = 4'd5;
    localparam logic [3:0] OP_NIP   = 4'd6;
    localparam logic [3:0] OP_ROT   = 4'd7;
    localparam logic [3:0] OP_NROT  = 4'd8;
    localparam logic [3:0] OP_SETT  = 4'd9;
    localparam logic [3:0] OP_BINOP = 4'd10;
    localparam logic [3:0] OP_CLEAR = 4'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] spill_mem [MEM_N];
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_en;
    logic             mem_we;
    logic [DSS-1:0]   mem_wa;
    logic [WIDTH-1:0] mem_wd;

    logic [DSS-1:0]   ptr2, ptr3;
    logic [DW-1:0]    depth_inc, depth_dec;
    logic             under, over;

    // Pointers to the slot below N (d-2) and the third entry (d-3), wrapping.
    assign ptr2      = DSS'(depth_q - DW'(2));
    assign ptr3      = DSS'(depth_q - DW'(3));
    assign depth_inc = (depth_q == CAP)   ? CAP  : depth_q + DW'(1);
    assign depth_dec = (depth_q == '0)    ? '0   : depth_q - DW'(1);

`ifdef PRIM_DSTACK_GUARD_EN
    // Depth legality of the requested op against the current depth.
    always_comb begin
        under = 1'b0;
        over  = 1'b0;
        case (i_op)
            OP_PUSH:                    over  = (depth_q == CAP);
            OP_DUP: begin
                under = (depth_q < DW'(1));
                over  = (depth_q == CAP);
            end
            OP_OVER: begin
                under = (depth_q < DW'(2));
                over  = (depth_q == CAP);
            end
            OP_DROP:                    under = (depth_q < DW'(1));
            OP_SWAP, OP_NIP, OP_BINOP:  under = (depth_q < DW'(2));
            OP_ROT, OP_NROT:            under = (depth_q < DW'(3));
            default: ;
        endcase
    end
`else
    assign under = 1'b0;
    assign over  = 1'b0;
`endif

    // Next-state, stack update and array port control.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        n_d     = n_q;
        depth_d = depth_q;
        op_d    = op_q;
        data_d  = data_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        rd_en   = 1'b0;
        mem_we  = 1'b0;
        mem_wa  = ptr2;
        mem_wd  = n_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (under) begin
                        unf_d = 1'b1;
                    end else if (over) begin
                        ovf_d = 1'b1;
                    end else begin
                        case (i_op)
                            OP_PUSH, OP_DUP, OP_OVER: begin
                                mem_we  = (depth_q >= DW'(2));
                                n_d     = t_q;
                                depth_d = depth_inc;
                                if (i_op == OP_PUSH)      t_d = i_data;
                                else if (i_op == OP_OVER) t_d = n_q;
                            end
                            OP_SWAP: begin
                                t_d = n_q;
                                n_d = t_q;
                            end
                            OP_SETT:  t_d     = i_data;
                            OP_CLEAR: depth_d = '0;
                            OP_DROP, OP_NIP, OP_BINOP, OP_ROT, OP_NROT: begin
                                rd_en   = 1'b1;
                                op_d    = i_op;
                                data_d  = i_data;
                                state_d = ST_READ;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_READ: begin
                state_d = ST_IDLE;
                case (op_q)
                    OP_DROP: begin
                        t_d     = n_q;
                        n_d     = rd_data_q;
                        depth_d = depth_dec;
                    end
                    OP_NIP: begin
                        n_d     = rd_data_q;
                        depth_d = depth_dec;
                    end
                    OP_BINOP: begin
                        t_d     = data_q;
                        n_d     = rd_data_q;
                        depth_d = depth_dec;
                    end
                    OP_ROT: begin
                        mem_we = 1'b1;
                        mem_wa = ptr3;
                        mem_wd = n_q;
                        t_d    = rd_data_q;
                        n_d    = t_q;
                    end
                    OP_NROT: begin
                        mem_we = 1'b1;
                        mem_wa = ptr3;
                        mem_wd = t_q;
                        t_d    = n_q;
                        n_d    = rd_data_q;
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and cached-entry registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            n_q     <= '0;
            depth_q <= '0;
            op_q    <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            n_q     <= n_d;
            depth_q <= depth_d;
            op_q    <= op_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Spill array: unreset, registered read, writes blocked while in reset.
    always_ff @(posedge i_clk) begin
        if (mem_we && i_reset_n) spill_mem[mem_wa] <= mem_wd;
        if (rd_en) rd_data_q <= spill_mem[ptr3];
    end

    assign o_ready     = (state_q == ST_IDLE);
    assign o_t         = t_q;
    assign o_n         = n_q;
    assign o_depth     = depth_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule
